alarm_controller: RTL and testbench
===================================

# alarm_controller

Alarm sequencing FSM for the alarm clock. Compares the running time against the programmed alarm time and drives the buzzer. Handles snooze (with a limit), stop and ring timeout, counting seconds with the single-cycle 1 Hz tick that the slow-clock divider produces. Sits between the timekeeping counters and the buzzer/LED outputs.

## Interface
- RING_TIMEOUT, 60, seconds of continuous ringing before automatic stop (≥2)
- SNOOZE_SEC, 300, seconds spent in snooze before ringing resumes (≥2)
- MAX_SNOOZE, 3, maximum snoozes per alarm event (1..7)
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- tick_1hz  in  1  one-cycle pulse, once per second
- cur_hour  in  5  current hour, 0..23
- cur_min  in  6  current minute, 0..59
- alarm_hour  in  5  programmed alarm hour
- alarm_min  in  6  programmed alarm minute
- alarm_en  in  1  alarm armed (level)
- snooze_btn  in  1  debounced one-cycle pulse
- stop_btn  in  1  debounced one-cycle pulse
- ringing  out  1  high in RINGING
- buzzer  out  1  square wave at 0.5 Hz while ringing, else 0
- snoozing  out  1  high in SNOOZE
- snooze_num  out  3  snoozes taken in the current event
- state  out  2  IDLE=0, RINGING=1, SNOOZE=2, ACKED=3

## Operation
- match = alarm_en && cur_hour==alarm_hour && cur_min==alarm_min. Combinational, evaluated every cycle.
- Priority each cycle, highest first: reset, then alarm_en==0, then stop_btn, then snooze_btn, then tick-driven events.
- alarm_en==0 in any state: go to IDLE and clear all counters and snooze_num.
- IDLE: if match, go to RINGING. ring_cnt=0, buzzer=1, snooze_num=0.
- RINGING:
  - stop_btn: go to ACKED.
  - snooze_btn with snooze_num<MAX_SNOOZE: go to SNOOZE. snooze_cnt=0, snooze_num+1.
  - snooze_btn with snooze_num==MAX_SNOOZE: ignored, stay RINGING.
  - tick_1hz: if ring_cnt==RING_TIMEOUT-1, go to ACKED; else ring_cnt+1 and buzzer toggles.
- SNOOZE:
  - stop_btn: go to ACKED.
  - snooze_btn: ignored.
  - tick_1hz: if snooze_cnt==SNOOZE_SEC-1, go to RINGING with ring_cnt=0 and buzzer=1; else snooze_cnt+1.
- ACKED: stay until match==0, then go to IDLE. This prevents re-triggering within the alarm minute. snooze_num holds its value until IDLE.
- stop_btn and snooze_btn in the same cycle: stop wins.
- Alarm time is not re-checked in RINGING/SNOOZE. Changing alarm_hour/alarm_min mid-event does not end the event.
- Counters size to hold parameter-1 and never wrap. Values at/above limit are unreachable.
- buzzer=0 in every state except RINGING.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, ringing=0, buzzer=0, snoozing=0, snooze_num=0. Internal ring_cnt=0, snooze_cnt=0.
- Reset is sampled at the clk edge and overrides any in-flight event, including one in the same cycle as match or tick.
- match true at edge N: ringing=1 and buzzer=1 after edge N.
- stop/snooze pulse sampled at edge N: outputs reflect the new state after edge N (1-cycle latency).
- RINGING entered at edge E with no further input:
  - buzzer toggles on each of the next RING_TIMEOUT-1 ticks.
  - On the RING_TIMEOUT-th tick the FSM goes to ACKED and buzzer=0.
- SNOOZE returns to RINGING on the SNOOZE_SEC-th tick after entry.
- tick_1hz coinciding with a button: the button transition takes effect and the tick is discarded.

## Test plan
- Reset: hold reset=0 with match true for 3 cycles, then release. state=0 and all outputs 0 during reset; state=1 one cycle after release.
- Basic ring/stop: alarm 07:30, time 07:30, alarm_en=1 gives ringing=1 next cycle. After 3 ticks buzzer has gone 1,0,1,0. stop_btn gives state=3. Time advances to 07:31 gives state=0.
- Timeout: RING_TIMEOUT=4, no buttons. Goes to ACKED on the 4th tick, buzzer=0, with no re-ring while still 07:30.
- Snooze limit: SNOOZE_SEC=3, MAX_SNOOZE=2.
  - snooze, 3 ticks, re-ring, snooze, 3 ticks, re-ring. snooze_num=2.
  - A third snooze_btn is ignored: state stays 1.
- Priority: stop_btn and snooze_btn in the same cycle gives state=3, snooze_num unchanged. A tick in the same cycle as snooze_btn gives state=2, snooze_cnt=0.
- Disarm: alarm_en 1→0 while in SNOOZE gives state=0 and snooze_num=0 next cycle. Re-arming within the alarm minute rings again.

Source files
------------

// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - alarm sequencing FSM with snooze limit, stop and ring timeout
module alarm_controller #(
    parameter int RING_TIMEOUT = 60,
    parameter int SNOOZE_SEC   = 300,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       alarm_en,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       ringing,
    output logic       buzzer,
    output logic       snoozing,
    output logic [2:0] snooze_num,
    output logic [1:0] state
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RINGING = 2'd1;
    localparam logic [1:0] SNOOZE  = 2'd2;
    localparam logic [1:0] ACKED   = 2'd3;
    localparam int RW = $clog2(RING_TIMEOUT);
    localparam int SW = $clog2(SNOOZE_SEC);

    logic [1:0]    state_q, state_n;
    logic [RW-1:0] ring_cnt_q, ring_cnt_n;
    logic [SW-1:0] snooze_cnt_q, snooze_cnt_n;
    logic [2:0]    snooze_num_q, snooze_num_n;
    logic          buzz_q, buzz_n;
    logic          match;

    assign match = alarm_en && (cur_hour == alarm_hour) && (cur_min == alarm_min);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            ring_cnt_q   <= '0;
            snooze_cnt_q <= '0;
            snooze_num_q <= '0;
            buzz_q       <= 1'b0;
        end else begin
            state_q      <= state_n;
            ring_cnt_q   <= ring_cnt_n;
            snooze_cnt_q <= snooze_cnt_n;
            snooze_num_q <= snooze_num_n;
            buzz_q       <= buzz_n;
        end
    end

    // Buttons pre-empt the tick; an ignored snooze lets the tick through.
    always_comb begin
        state_n      = state_q;
        ring_cnt_n   = ring_cnt_q;
        snooze_cnt_n = snooze_cnt_q;
        snooze_num_n = snooze_num_q;
        buzz_n       = buzz_q;
        if (!alarm_en) begin
            state_n      = IDLE;
            ring_cnt_n   = '0;
            snooze_cnt_n = '0;
            snooze_num_n = '0;
            buzz_n       = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (match) begin
                        state_n      = RINGING;
                        ring_cnt_n   = '0;
                        buzz_n       = 1'b1;
                        snooze_num_n = '0;
                    end
                end
                RINGING: begin
                    if (stop_btn) begin
                        state_n = ACKED;
                        buzz_n  = 1'b0;
                    end else if (snooze_btn && (snooze_num_q < 3'(MAX_SNOOZE))) begin
                        state_n      = SNOOZE;
                        snooze_cnt_n = '0;
                        snooze_num_n = snooze_num_q + 3'd1;
                        buzz_n       = 1'b0;
                    end else if (tick_1hz) begin
                        if (ring_cnt_q == RW'(RING_TIMEOUT - 1)) begin
                            state_n = ACKED;
                            buzz_n  = 1'b0;
                        end else begin
                            ring_cnt_n = ring_cnt_q + RW'(1);
                            buzz_n     = !buzz_q;
                        end
                    end
                end
                SNOOZE: begin
                    if (stop_btn) begin
                        state_n = ACKED;
                    end else if (tick_1hz) begin
                        if (snooze_cnt_q == SW'(SNOOZE_SEC - 1)) begin
                            state_n    = RINGING;
                            ring_cnt_n = '0;
                            buzz_n     = 1'b1;
                        end else begin
                            snooze_cnt_n = snooze_cnt_q + SW'(1);
                        end
                    end
                end
                default: begin
                    buzz_n = 1'b0;
                    if (!match) begin
                        state_n      = IDLE;
                        ring_cnt_n   = '0;
                        snooze_cnt_n = '0;
                        snooze_num_n = '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        state      = state_q;
        ringing    = (state_q == RINGING);
        snoozing   = (state_q == SNOOZE);
        buzzer     = buzz_q;
        snooze_num = snooze_num_q;
    end
endmodule

// File: tb/tb_alarm_controller.sv
// tb/tb_alarm_controller.sv - directed self-checking bench for alarm_controller
module tb_alarm_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick_1hz = 1'b0;
    logic [4:0] cur_hour = 5'd7;
    logic [5:0] cur_min = 6'd30;
    logic [4:0] alarm_hour = 5'd7;
    logic [5:0] alarm_min = 6'd30;
    logic       alarm_en = 1'b1;
    logic       snooze_btn = 1'b0;
    logic       stop_btn = 1'b0;
    logic       ringing, buzzer, snoozing;
    logic [2:0] snooze_num;
    logic [1:0] state;
    int checks = 0;
    int errors = 0;

    alarm_controller #(.RING_TIMEOUT(4), .SNOOZE_SEC(3), .MAX_SNOOZE(2)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
        .cur_hour(cur_hour), .cur_min(cur_min),
        .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .alarm_en(alarm_en), .snooze_btn(snooze_btn), .stop_btn(stop_btn),
        .ringing(ringing), .buzzer(buzzer), .snoozing(snoozing),
        .snooze_num(snooze_num), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge: drive inputs for one posedge, return at the next negedge.
    task automatic cyc(input logic t, input logic s, input logic p);
        tick_1hz = t; snooze_btn = s; stop_btn = p;
        @(negedge clk);
        tick_1hz = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            check("rst_state", state, 0);
            check("rst_outs", {ringing, buzzer, snoozing}, 0);
            check("rst_num", snooze_num, 0);
        end
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        check("ring_state", state, 1);
        check("ring_outs", {ringing, buzzer, snoozing}, 3'b110);

        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            check("toggle", buzzer, (i % 2 == 0) ? 0 : 1);
        end
        check("still_ring", state, 1);
        cyc(1'b0, 1'b0, 1'b1);
        check("stop_state", state, 3);
        check("stop_outs", {ringing, buzzer, snoozing}, 0);
        cyc(1'b0, 1'b0, 1'b0);
        check("acked_hold", state, 3);
        cur_min = 6'd31;
        cyc(1'b0, 1'b0, 1'b0);
        check("acked_idle", state, 0);

        cur_min = 6'd30;
        cyc(1'b0, 1'b0, 1'b0);
        check("to_ring", state, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            check("to_toggle", buzzer, (i % 2 == 0) ? 0 : 1);
            check("to_state", state, 1);
        end
        cyc(1'b1, 1'b0, 1'b0);
        check("to_acked", state, 3);
        check("to_buzz", buzzer, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            check("to_norering", state, 3);
        end
        cur_min = 6'd31;
        cyc(1'b0, 1'b0, 1'b0);
        check("to_idle", state, 0);

        cur_min = 6'd30;
        cyc(1'b0, 1'b0, 1'b0);
        for (int n = 1; n <= 2; n++) begin
            cyc(1'b0, 1'b1, 1'b0);
            check("sn_state", state, 2);
            check("sn_num", snooze_num, n);
            check("sn_outs", {ringing, buzzer, snoozing}, 3'b001);
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b1, 1'b0);
            cyc(1'b1, 1'b0, 1'b0);
            check("sn_wait", state, 2);
            cyc(1'b1, 1'b0, 1'b0);
            check("sn_rering", state, 1);
            check("sn_rebuzz", buzzer, 1);
        end
        cyc(1'b0, 1'b1, 1'b0);
        check("sn_limit", state, 1);
        check("sn_limit_num", snooze_num, 2);
        cyc(1'b0, 1'b1, 1'b1);
        check("both_state", state, 3);
        check("both_num", snooze_num, 2);
        cur_min = 6'd31;
        cyc(1'b0, 1'b0, 1'b0);
        check("both_idle_num", snooze_num, 0);

        cur_min = 6'd30;
        cyc(1'b0, 1'b0, 1'b0);
        alarm_min = 6'd45;
        cyc(1'b1, 1'b0, 1'b0);
        check("moved_alarm", state, 1);
        alarm_min = 6'd30;
        cyc(1'b1, 1'b1, 1'b0);
        check("tick_snz", state, 2);
        check("tick_snz_num", snooze_num, 1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("tick_snz_cnt0", state, 2);
        cyc(1'b1, 1'b0, 1'b0);
        check("tick_snz_back", state, 1);

        cyc(1'b0, 1'b1, 1'b0);
        check("dis_pre", state, 2);
        alarm_en = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        check("dis_state", state, 0);
        check("dis_num", snooze_num, 0);
        check("dis_snoozing", snoozing, 0);
        alarm_en = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        check("rearm", state, 1);

        reset = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        check("rst_mid", state, 0);
        check("rst_mid_buzz", buzzer, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
